// File: rtl/dm_store_buffer_pkg.sv
// Shared types for the store buffer: store-type codes, drain FSM states, the
// buffered entry layout and the sw/sh/sb lane encoder.
package dm_store_buffer_pkg;

    localparam logic [1:0] WORD_WRITE = 2'b00;
    localparam logic [1:0] HALF_WRITE = 2'b01;
    localparam logic [1:0] BYTE_WRITE = 2'b10;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_t;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
    } st_entry_t;

    typedef struct packed {
        logic      ok;
        st_entry_t entry;
    } st_enc_t;

    // An unknown store type leaves ok low, so it is dropped like a misaligned store.
    function automatic st_enc_t encode_store(input logic [1:0]  st_type,
                                             input logic [31:0] addr,
                                             input logic [31:0] data);
        st_enc_t r;
        r.ok           = 1'b0;
        r.entry.waddr  = addr[31:2];
        r.entry.wdata  = data;
        r.entry.byteen = 4'b0000;
        case (st_type)
            WORD_WRITE: begin
                r.ok           = (addr[1:0] == 2'b00);
                r.entry.byteen = 4'b1111;
            end
            HALF_WRITE: begin
                r.ok           = ~addr[0];
                r.entry.byteen = addr[1] ? 4'b1100 : 4'b0011;
                r.entry.wdata  = {2{data[15:0]}};
            end
            BYTE_WRITE: begin
                r.ok           = 1'b1;
                r.entry.byteen = 4'b0001 << addr[1:0];
                r.entry.wdata  = {4{data[7:0]}};
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_store_buffer_store_fifo.sv
// Circular store queue; exposes every slot's valid bit and word address so the
// top can compare a load against all pending stores in one cycle.
module store_fifo
    import dm_store_buffer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic                    push_i,
    input  st_entry_t               push_entry_i,
    input  logic                    pop_i,
    output st_entry_t               head_o,
    output st_entry_t               next_head_o,
    output logic [PTR_W:0]          count_o,
    output logic [DEPTH-1:0]        valid_o,
    output logic [DEPTH-1:0][29:0]  waddr_o
);

    st_entry_t        entries_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] offset;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            entries_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // A slot is occupied when its distance from the read pointer is below count.
    always_comb begin
        valid_o = '0;
        offset  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset     = PTR_W'(i) - rd_ptr_q;
            valid_o[i] = ({1'b0, offset} < count_q);
            waddr_o[i] = entries_q[i].waddr;
        end
    end

    assign head_o      = entries_q[rd_ptr_q];
    assign next_head_o = entries_q[rd_ptr_q + PTR_W'(1)];
    assign count_o     = count_q;

endmodule

// File: rtl/dm_store_buffer.sv
// MEM-stage store buffer: encodes sw/sh/sb into word address, byte enables and
// replicated lanes, queues them and drains one per acknowledged DM request.
module dm_store_buffer
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         st_valid,
    input  logic [1:0]   st_type,
    input  logic [31:0]  st_addr,
    input  logic [31:0]  st_data,
    output logic         st_ready,
    output logic         align_err,
    input  logic [31:0]  ld_addr,
    output logic         ld_conflict,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    output logic [3:0]   mem_byteen,
    input  logic         mem_ack,
    output logic         empty,
    output drain_state_t dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);

    st_enc_t                 enc;
    logic                    push, pop;
    st_entry_t               head, next_head;
    logic [PTR_W:0]          count;
    logic [DEPTH-1:0]        slot_valid;
    logic [DEPTH-1:0][29:0]  slot_waddr;
    drain_state_t            state_q, state_d;
    st_entry_t               out_q, out_d;
    logic                    align_err_q;

    assign enc      = encode_store(st_type, st_addr, st_data);
    assign st_ready = (count != (PTR_W+1)'(DEPTH));
    assign push     = st_valid && st_ready && enc.ok;

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset_i      (reset),
        .push_i       (push),
        .push_entry_i (enc.entry),
        .pop_i        (pop),
        .head_o       (head),
        .next_head_o  (next_head),
        .count_o      (count),
        .valid_o      (slot_valid),
        .waddr_o      (slot_waddr)
    );

    // The presented request is a registered copy of the head, so it stays stable until acked.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        pop     = 1'b0;
        case (state_q)
            DRAIN_IDLE: begin
                if (count != '0) begin
                    state_d = DRAIN_REQ;
                    out_d   = head;
                end
            end
            DRAIN_REQ: begin
                if (mem_ack) begin
                    pop = 1'b1;
                    if (count > (PTR_W+1)'(1)) begin
                        out_d = next_head;
                    end else begin
                        state_d = DRAIN_IDLE;
                        out_d   = '0;
                    end
                end
            end
            default: begin
                state_d = DRAIN_IDLE;
                out_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DRAIN_IDLE;
            out_q       <= '0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            align_err_q <= st_valid && st_ready && !enc.ok;
        end
    end

    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && (slot_waddr[i] == ld_addr[31:2])) begin
                ld_conflict = 1'b1;
            end
        end
    end

    assign mem_req    = (state_q == DRAIN_REQ);
    assign mem_addr   = {out_q.waddr, 2'b00};
    assign mem_wdata  = out_q.wdata;
    assign mem_byteen = out_q.byteen;
    assign align_err  = align_err_q;
    assign empty      = (count == '0) && !mem_req;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: queue-based reference model checked every cycle,
// directed cases with literal expectations, then randomized traffic.
module tb_dm_store_buffer;
    import dm_store_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         st_valid = 1'b0;
    logic [1:0]   st_type = 2'b00;
    logic [31:0]  st_addr = '0;
    logic [31:0]  st_data = '0;
    logic         st_ready;
    logic         align_err;
    logic [31:0]  ld_addr = '0;
    logic         ld_conflict;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_byteen;
    logic         mem_ack = 1'b0;
    logic         empty;
    drain_state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    // Model state: pending stores in issue order as {addr, wdata, byteen}.
    logic [67:0] exp_q[$];
    logic        m_req = 1'b0;
    logic        m_align = 1'b0;
    int          m_pushed = 0;
    int          m_discarded = 0;
    int          hs_cnt = 0;
    int          m_n;
    logic [68:0] m_e;
    logic        m_conf;

    always #5 clk = ~clk;

    dm_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .st_valid    (st_valid),
        .st_type     (st_type),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_ready    (st_ready),
        .align_err   (align_err),
        .ld_addr     (ld_addr),
        .ld_conflict (ld_conflict),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_byteen  (mem_byteen),
        .mem_ack     (mem_ack),
        .empty       (empty),
        .dbg_state   (dbg_state)
    );

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {ok, word address, replicated data, byte enables}.
    function automatic logic [68:0] model_encode(input logic [1:0] t, input logic [31:0] a,
                                                 input logic [31:0] d);
        logic       ok;
        logic [3:0] be;
        logic [31:0] wd;
        ok = 1'b0; be = 4'h0; wd = 32'h0;
        if (t == WORD_WRITE) begin
            ok = (a % 4 == 0); be = 4'hF; wd = d;
        end else if (t == HALF_WRITE) begin
            ok = (a % 2 == 0); be = (a % 4 == 2) ? 4'hC : 4'h3; wd = d[15:0] * 32'h0001_0001;
        end else if (t == BYTE_WRITE) begin
            ok = 1'b1; be = 4'(1 << (a % 4)); wd = d[7:0] * 32'h0101_0101;
        end
        return {ok, a & 32'hFFFF_FFFC, wd, be};
    endfunction

    // Reference model: advance on each rising edge using the inputs seen before it.
    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_discarded = m_discarded + exp_q.size();
            exp_q.delete();
            m_req   = 1'b0;
            m_align = 1'b0;
        end else begin
            m_n = exp_q.size();
            if (m_req && mem_ack) begin
                void'(exp_q.pop_front());
                m_req = (m_n > 1);
            end else if (!m_req && m_n != 0) begin
                m_req = 1'b1;
            end
            m_align = 1'b0;
            if (st_valid && m_n != DEPTH) begin
                m_e = model_encode(st_type, st_addr, st_data);
                if (m_e[68]) begin
                    exp_q.push_back(m_e[67:0]);
                    m_pushed++;
                end else begin
                    m_align = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare on the falling edge.
    initial forever begin
        @(negedge clk);
        if (started) begin
            check("mem_req", 68'(mem_req), 68'(m_req));
            if (m_req && exp_q.size() != 0)
                check("head", {mem_addr, mem_wdata, mem_byteen}, exp_q[0]);
            check("st_ready", 68'(st_ready), 68'(exp_q.size() != DEPTH));
            check("empty", 68'(empty), 68'(exp_q.size() == 0 && !m_req));
            check("align_err", 68'(align_err), 68'(m_align));
            m_conf = 1'b0;
            foreach (exp_q[i]) if (exp_q[i][67:38] == ld_addr[31:2]) m_conf = 1'b1;
            check("ld_conflict", 68'(ld_conflict), 68'(m_conf));
            if (mem_req && mem_ack) hs_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1; st_type = t; st_addr = a; st_data = d;
    endtask

    task automatic store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        drive(t, a, d);
        step();
        st_valid = 1'b0;
    endtask

    initial begin
        logic pushed;
        int   guard;

        step();
        started = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mem_req", 68'(mem_req), 68'(0));
        check("rst_st_ready", 68'(st_ready), 68'(1));
        check("rst_empty", 68'(empty), 68'(1));
        check("rst_align_err", 68'(align_err), 68'(0));
        check("rst_mem_addr", 68'(mem_addr), 68'(0));

        // sb with one-cycle-later request
        store(BYTE_WRITE, 32'h1003, 32'h0000_00AB);
        check("sb_latency", 68'(mem_req), 68'(0));
        step();
        check("sb_req", 68'(mem_req), 68'(1));
        check("sb_addr", 68'(mem_addr), 68'(32'h1000));
        check("sb_be", 68'(mem_byteen), 68'(4'b1000));
        check("sb_wdata", 68'(mem_wdata), 68'(32'hABAB_ABAB));
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        check("sb_drained", 68'(empty), 68'(1));

        store(HALF_WRITE, 32'h2002, 32'h0000_1234);
        step();
        check("sh_be", 68'(mem_byteen), 68'(4'b1100));
        check("sh_wdata", 68'(mem_wdata), 68'(32'h1234_1234));
        mem_ack = 1'b1; step(); mem_ack = 1'b0;

        store(HALF_WRITE, 32'h2001, 32'h0000_5555);
        check("sh_mis_err", 68'(align_err), 68'(1));
        step();
        check("sh_mis_pulse", 68'(align_err), 68'(0));
        check("sh_mis_noreq", 68'(mem_req), 68'(0));
        check("sh_mis_empty", 68'(empty), 68'(1));

        // fill to full, then drain back-to-back while the 5th waits
        for (int i = 0; i < 4; i++) begin
            drive(WORD_WRITE, 32'h100 + 32'(4 * i), 32'(i));
            step();
        end
        check("full_ready", 68'(st_ready), 68'(0));
        drive(WORD_WRITE, 32'h110, 32'd4);
        mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("b2b_req", 68'(mem_req), 68'(1));
            check("b2b_addr", 68'(mem_addr), 68'(32'h100 + 32'(4 * i)));
            pushed = st_valid && st_ready;
            step();
            if (pushed) st_valid = 1'b0;
        end
        mem_ack = 1'b0;
        check("b2b_idle", 68'(mem_req), 68'(0));
        check("b2b_empty", 68'(empty), 68'(1));

        // load/store conflict
        store(WORD_WRITE, 32'h3000, 32'hDEAD_BEEF);
        ld_addr = 32'h3002; #1;
        check("conf_hit", 68'(ld_conflict), 68'(1));
        ld_addr = 32'h3004; #1;
        check("conf_miss", 68'(ld_conflict), 68'(0));
        ld_addr = 32'h3002;
        step();
        check("conf_head", 68'(ld_conflict), 68'(1));
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        check("conf_popped", 68'(ld_conflict), 68'(0));

        // reset during an outstanding request
        for (int i = 0; i < 3; i++) store(WORD_WRITE, 32'h500 + 32'(4 * i), 32'(i));
        check("mid_req", 68'(mem_req), 68'(1));
        reset = 1'b1; step(); reset = 1'b0;
        check("mid_rst_req", 68'(mem_req), 68'(0));
        check("mid_rst_empty", 68'(empty), 68'(1));
        check("mid_rst_ready", 68'(st_ready), 68'(1));

        // randomized traffic with ack gaps and pointer wrap
        for (int c = 0; c < 400; c++) begin
            st_valid = ($urandom_range(0, 3) != 0);
            st_type  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            st_addr  = 32'h4000 + 32'($urandom_range(0, 15));
            st_data  = $urandom;
            ld_addr  = 32'h4000 + 32'($urandom_range(0, 15));
            mem_ack  = ($urandom_range(0, 2) == 0);
            step();
        end
        st_valid = 1'b0;
        mem_ack  = 1'b1;
        guard    = 0;
        while (!empty && guard < 50) begin
            step();
            guard++;
        end
        mem_ack = 1'b0;
        check("drain_done", 68'(empty), 68'(1));
        check("no_loss_dup", 68'(hs_cnt), 68'(m_pushed - m_discarded));
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

endmodule
